fsm_scan_ctrl: RTL

- Serial debug/test front end that drives the controller FSM's scan interface (scan_en/scan_state) and reads back its live state register.
- Deserialises 6-bit command frames from a tester pin pair (sframe/sdi).
- A write frame issues one scan_en pulse carrying a 5-bit target state; a read frame captures the FSM state and serialises it on sdo.
- Sits between the chip-level test pins and the controller FSM, in the same clock domain.

---
 rtl/fsm_scan_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fsm_scan_ctrl.sv
// fsm_scan_ctrl: serial test-port front end for the controller FSM.
// Each frame carries 6 bits on sdi while sframe is high: a command bit
// (1 = write, 0 = read) and then a 5-bit value, MSB first. A write issues one
// scan_en pulse that loads the value into the FSM. A read captures the live
// state and shifts it out on sdo. All outputs are registered.
module fsm_scan_ctrl #(
  parameter int SW        = 5,
  parameter int MAX_STATE = 30
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sframe,
  input  logic          sdi,
  input  logic [SW-1:0] state,
  output logic          scan_en,
  output logic [SW-1:0] scan_state,
  output logic          sdo,
  output logic          sdo_valid,
  output logic          busy,
  output logic          err
);

  localparam int            CW    = $clog2(SW + 1);
  localparam logic [SW-1:0] MAX_V = SW'(MAX_STATE);
  localparam logic [CW-1:0] LAST  = CW'(SW - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_APPLY, S_OUT} fsm_t;

  fsm_t          fsm;
  logic          sframe_q;
  logic          cmd;
  logic [SW-1:0] shreg;
  logic [CW-1:0] bit_cnt;
  logic [SW-1:0] shift_next;

  assign shift_next = {shreg[SW-2:0], sdi};

  // Frame decoder, scan strobe generator and read-back serialiser in one FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm        <= S_IDLE;
      sframe_q   <= 1'b0;
      cmd        <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      scan_en    <= 1'b0;
      scan_state <= '0;
      sdo        <= 1'b0;
      sdo_valid  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      sframe_q <= sframe;
      scan_en  <= 1'b0;
      err      <= 1'b0;
      case (fsm)
        S_IDLE: begin
          // Only a sampled rising edge opens a frame; a held-high strobe does not.
          if (sframe && !sframe_q) begin
            cmd     <= sdi;
            bit_cnt <= '0;
            busy    <= 1'b1;
            fsm     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!sframe) begin
            // Strobe dropped before all data bits arrived: discard the frame.
            err  <= 1'b1;
            busy <= 1'b0;
            fsm  <= S_IDLE;
          end else begin
            shreg   <= shift_next;
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == LAST) begin
              bit_cnt <= '0;
              if (cmd) begin
                if (shift_next > MAX_V) begin
                  err  <= 1'b1;
                  busy <= 1'b0;
                  fsm  <= S_IDLE;
                end else begin
                  scan_en    <= 1'b1;
                  scan_state <= shift_next;
                  fsm        <= S_APPLY;
                end
              end else begin
                // MSB goes out now; the rest waits in shreg, left-justified.
                sdo       <= state[SW-1];
                shreg     <= {state[SW-2:0], 1'b0};
                sdo_valid <= 1'b1;
                fsm       <= S_OUT;
              end
            end
          end
        end
        S_APPLY: begin
          // sframe_q is always 1 here, so a high sframe means an overlong frame.
          err  <= sframe;
          busy <= 1'b0;
          fsm  <= S_IDLE;
        end
        S_OUT: begin
          // First cycle: held-over strobe; later cycles: a fresh rising edge.
          err <= sframe && ((bit_cnt == '0) || !sframe_q);
          if (bit_cnt == LAST) begin
            sdo       <= 1'b0;
            sdo_valid <= 1'b0;
            busy      <= 1'b0;
            bit_cnt   <= '0;
            fsm       <= S_IDLE;
          end else begin
            sdo     <= shreg[SW-1];
            shreg   <= {shreg[SW-2:0], 1'b0};
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: begin
          busy <= 1'b0;
          fsm  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
